// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   CLA_GROUP   : bits resolved by one lookahead group
//   cla_groups(): number of lookahead groups needed for a given operand width
package cla_pkg;

    localparam int CLA_GROUP = 4;

    function automatic int cla_groups(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group (purely combinational).
// Ports:
//   a, b  : 4-bit operand slices (b already in its effective, possibly inverted, form)
//   cin   : carry into bit 0 of the group
//   s     : 4-bit sum slice
//   cout  : carry out of bit 3
//   P, G  : group propagate / generate
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       P,
    output logic       G
);

    logic [3:0] pv;
    logic [3:0] gv;
    logic [3:0] c;

    assign pv = a ^ b;
    assign gv = a & b;

    // Every internal carry is expanded directly from cin, so no carry
    // ripples inside the group.
    assign c[0] = cin;
    assign c[1] = gv[0] | (pv[0] & cin);
    assign c[2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & cin);
    assign c[3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0])
                | (pv[2] & pv[1] & pv[0] & cin);

    assign P = &pv;
    assign G = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1])
             | (pv[3] & pv[2] & pv[1] & gv[0]);

    assign s    = pv ^ c;
    assign cout = G | (P & cin);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor built from 4-bit carry-lookahead groups whose
// carries ripple from group to group.  The groups are split evenly over
// STAGES register stages; each stage resolves its slice of groups and
// registers the partial sum, the carry into the next slice, the operand
// bits not yet consumed, and the sub flag.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (a, b, sub, cin)
//   a, b                 : WIDTH-bit operands
//   sub                  : 0 = a + b + cin, 1 = a - b (cin ignored)
//   cin                  : carry-in, add mode only
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sum                  : result modulo 2^WIDTH
//   cout                 : carry out of the MSB (subtract: 1 = no borrow)
//   ovf                  : two's-complement signed overflow
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its data until that edge; ready never depends
// on valid.  While out_valid && !out_ready the result outputs hold steady.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG  = cla_groups(WIDTH);     // total groups
    localparam int GPS = NG / STAGES;           // groups per stage
    localparam int SW  = GPS * CLA_GROUP;       // bits resolved per stage
    localparam int L   = STAGES - 1;            // index of the output stage

    logic [STAGES-1:0] v_q;   // stage holds a live operation
    logic [STAGES-1:0] ld;    // stage loads on the next edge

    // A stage can load if it, or any stage after it, has room, or if the
    // consumer takes the result.  Written as a flat OR so there is no
    // combinational chain through ld itself.
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            ld[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!v_q[j]) begin
                    ld[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = rst_n & ld[0];
    assign out_valid = v_q[L];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            if (ld[0]) begin
                v_q[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_q[k-1];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int HI = (k + 1) * SW;   // sum bits resolved after this stage

        logic [SW-1:0]  sa;       // operand a slice for this stage
        logic [SW-1:0]  sb_raw;   // operand b slice as presented
        logic [SW-1:0]  sb;       // effective b slice
        logic [SW-1:0]  ss;       // sum slice
        logic           ssub;
        logic           scin;
        logic [GPS:0]   gc;       // carries between groups of this stage
        logic [GPS-1:0] p_unused; // group P/G are not needed: carries ripple via cout
        logic [GPS-1:0] g_unused;
        logic [HI-1:0]  s_nxt;
        logic [HI-1:0]  s_q;
        logic           c_q;

        if (k == 0) begin : src
            assign sa     = a[SW-1:0];
            assign sb_raw = b[SW-1:0];
            assign ssub   = sub;
            // Subtract is a + ~b + 1, so the carry-in is forced high.
            assign scin   = sub | cin;
            assign s_nxt  = ss;
        end else begin : src
            assign sa     = stg[k-1].fwd.a_q[SW-1:0];
            assign sb_raw = stg[k-1].fwd.b_q[SW-1:0];
            assign ssub   = stg[k-1].fwd.sub_q;
            assign scin   = stg[k-1].c_q;
            assign s_nxt  = {ss, stg[k-1].s_q};
        end

        // b travels raw and is inverted slice by slice where it is consumed.
        assign sb    = sb_raw ^ {SW{ssub}};
        assign gc[0] = scin;

        for (genvar j = 0; j < GPS; j++) begin : grp
            cla_group4 u_grp (
                .a    (sa[j*CLA_GROUP +: CLA_GROUP]),
                .b    (sb[j*CLA_GROUP +: CLA_GROUP]),
                .cin  (gc[j]),
                .s    (ss[j*CLA_GROUP +: CLA_GROUP]),
                .cout (gc[j+1]),
                .P    (p_unused[j]),
                .G    (g_unused[j])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ld[k]) begin
                s_q <= s_nxt;
                c_q <= gc[GPS];
            end
        end

        if (k < STAGES - 1) begin : fwd
            localparam int UW = WIDTH - HI;   // operand bits still unresolved

            logic [UW-1:0] a_nxt;
            logic [UW-1:0] b_nxt;
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;
            logic          sub_q;

            if (k == 0) begin : up
                assign a_nxt = a[WIDTH-1:HI];
                assign b_nxt = b[WIDTH-1:HI];
            end else begin : up
                assign a_nxt = stg[k-1].fwd.a_q[UW+SW-1:SW];
                assign b_nxt = stg[k-1].fwd.b_q[UW+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (ld[k]) begin
                    a_q   <= a_nxt;
                    b_q   <= b_nxt;
                    sub_q <= ssub;
                end
            end
        end else begin : fin
            logic ovf_q;

            // The last slice holds the MSB, so its operand and sum tops
            // are exactly the sign bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (ld[k]) begin
                    ovf_q <= (sa[SW-1] == sb[SW-1]) && (ss[SW-1] != sa[SW-1]);
                end
            end
        end
    end

    assign sum  = stg[L].s_q;
    assign cout = stg[L].c_q;
    assign ovf  = stg[L].fin.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, STAGES=2).
module tb_pipelined_cla_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Expected result packed as {ovf, cout, sum}
    logic [WIDTH+1:0] exp_q[$];
    int               pop_log[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc   = 0;
    bit               rnd_rdy = 0;

    pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic ms, input logic mc);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   r;
        logic             o;
        bb = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (ms | mc)};
        o  = (ma[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
        return {o, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : mon
        logic [WIDTH+1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", {ovf, cout, sum}, e);
                pop_log.push_back(cyc);
            end
        end
    end

    // Random back-pressure, active only in the random phase
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic ts, input logic tc, input logic [WIDTH+1:0] e);
        bit acc;
        bit done;
        exp_q.push_back(e);
        a = ta; b = tb_; sub = ts; cin = tc;
        in_valid = 1'b1;
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            done = acc;
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] st_a[4];
    logic [WIDTH-1:0] st_b[4];
    logic             st_s[4];
    logic             st_c[4];

    initial begin
        int acc;
        logic [WIDTH-1:0] ra, rb;
        logic rs, rc;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_result", {ovf, cout, sum}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: result visible after exactly two edges
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
        in_valid = 1'b0;
        check("lat_edge1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2_out_valid", out_valid, 1);
        drain();

        // Directed corner cases (hand-derived expectations)
        send(16'hFFFF, 16'h0000, 1'b0, 1'b1, 18'h10000);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 18'h37FFF);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, 18'h10000);
        in_valid = 1'b0;
        drain();

        // 10 back-to-back operations -> 10 consecutive results
        pop_log.delete();
        for (int i = 0; i < 10; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rc, model(ra, rb, rs, rc));
        end
        in_valid = 1'b0;
        drain();
        check("burst_count", pop_log.size(), 10);
        for (int i = 1; i < 10 && i < pop_log.size(); i++) begin
            check("burst_consecutive", pop_log[i] - pop_log[0], i);
        end

        // Output stall with input held valid
        for (int i = 0; i < 4; i++) begin
            st_a[i] = WIDTH'($urandom); st_b[i] = WIDTH'($urandom);
            st_s[i] = 1'($urandom_range(0, 1)); st_c[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        acc = 0;
        a = st_a[0]; b = st_b[0]; sub = st_s[0]; cin = st_c[0];
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(st_a[acc], st_b[acc], st_s[acc], st_c[acc]));
                acc++;
            end
            if (out_valid && exp_q.size() > 0) check("stall_hold", {ovf, cout, sum}, exp_q[0]);
            @(posedge clk);
            #1;
            a = st_a[acc]; b = st_b[acc]; sub = st_s[acc]; cin = st_c[acc];
        end
        check("stall_accepts", acc, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            @(negedge clk);
            if (c == 0) check("full_release_in_ready", in_ready, 1);
            if (in_ready) begin
                exp_q.push_back(model(st_a[acc], st_b[acc], st_s[acc], st_c[acc]));
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc < 4) begin
                a = st_a[acc]; b = st_b[acc]; sub = st_s[acc]; cin = st_c[acc];
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("stall_total_accepts", acc, 4);
        drain();

        // Reset with two operations in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 18'h03333);
        send(16'h0F0F, 16'h0101, 1'b1, 1'b0, 18'h10E0E);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("inrst_out_valid", out_valid, 0);
        check("inrst_result", {ovf, cout, sum}, 0);
        check("inrst_in_ready", in_ready, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("postrst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure and input gaps
        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            if (i % 8 == 0) ra = 16'hFFFF;
            if (i % 8 == 4) ra = 16'h8000;
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rc, model(ra, rb, rs, rc));
        end
        in_valid = 1'b0;
        rnd_rdy = 0;
        @(posedge clk);
        #3;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
